// File: rtl/vec_inst_encoder.sv
// Purpose : encodes vector micro-op requests into 32-bit RVV words, queues them in a DEPTH-entry FIFO.
// Latency : a legal request accepted at edge N is visible on vec_inst/inst_valid right after edge N.
// Backpr. : req_ready drops when the FIFO is full or a vsetvli is in flight; it never looks at inst_ready.
//
// Ports:
//   clk, reset_n (async active-low), flush (sync clear, beats push/pop)
//   req_*        : request handshake and fields (class 0=ARITH 1=CFG 2=LOAD 3=STORE)
//   inst_valid/inst_ready/vec_inst : downstream handshake, head of FIFO
//   err_valid    : one-cycle pulse after an illegal request was accepted and dropped
//   err_code     : 1=bad funct3, 2=bad width, 3=mew set; sticky until the next error
//   fifo_count   : occupancy 0..DEPTH
module vec_inst_encoder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  input  logic [5:0]       req_funct6,
  input  logic             req_vm,
  input  logic [4:0]       req_vd,
  input  logic [4:0]       req_vs1,
  input  logic [4:0]       req_vs2,
  input  logic [2:0]       req_funct3,
  input  logic [10:0]      req_zimm,
  input  logic [2:0]       req_nf,
  input  logic             req_mew,
  input  logic [1:0]       req_mop,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      vec_inst,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [1:0] CLS_ARITH = 2'd0;
  localparam logic [1:0] CLS_CFG   = 2'd1;
  localparam logic [1:0] CLS_STORE = 2'd3;

  localparam logic [6:0] OP_V  = 7'h57;
  localparam logic [6:0] OP_LD = 7'h07;
  localparam logic [6:0] OP_ST = 7'h27;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  typedef enum logic {
    ST_RUN,
    ST_CFG_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [31:0]      enc_word;
  logic [1:0]       enc_err;
  logic             accept, push, pop;

  // Encoder: pure function of the request fields; enc_err==0 means legal.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 2'd0;
    case (req_class)
      CLS_ARITH: begin
        enc_word = {req_funct6, req_vm, req_vs2, req_vs1, req_funct3, req_vd, OP_V};
        if (!(req_funct3 inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b110})) begin
          enc_err = 2'd1;
        end
      end
      CLS_CFG: begin
        enc_word = {1'b0, req_zimm, req_vs1, 3'b111, req_vd, OP_V};
      end
      default: begin
        // LOAD and STORE share a layout; only the opcode differs.
        enc_word = {req_nf, req_mew, req_mop, req_vm, req_vs2, req_vs1, req_funct3, req_vd,
                    (req_class == CLS_STORE) ? OP_ST : OP_LD};
        // A bad width is reported in preference to mew.
        if (!(req_funct3 inside {3'b000, 3'b101, 3'b110, 3'b111})) begin
          enc_err = 2'd2;
        end else if (req_mew) begin
          enc_err = 2'd3;
        end
      end
    endcase
  end

  // Handshake: ready comes only from registered state.
  assign req_ready = (count_q < DEPTH_C) && (state_q == ST_RUN);
  assign accept    = req_valid & req_ready & ~flush;
  assign push      = accept & (enc_err == 2'd0);
  assign pop       = (count_q != '0) & inst_ready & ~flush;

  // FSM next state. In CFG_WAIT nothing is pushed behind the vsetvli, so it is
  // always the tail; it leaves the FIFO when the last remaining entry pops.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (push && (req_class == CLS_CFG)) state_d = ST_CFG_WAIT;
        ST_CFG_WAIT: if (pop && (count_q == ONE_C)) state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push) begin
      count_d = count_q - ONE_C;
    end
  end

  always_comb begin
    err_valid_d = accept & (enc_err != 2'd0);
    err_code_d  = err_valid_d ? enc_err : err_code_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= enc_word;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Head entry and count are both flops, so the output holds while stalled.
  assign vec_inst   = mem_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_vec_inst_encoder.sv
module tb_vec_inst_encoder;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_class;
  logic [5:0]  req_funct6;
  logic        req_vm;
  logic [4:0]  req_vd;
  logic [4:0]  req_vs1;
  logic [4:0]  req_vs2;
  logic [2:0]  req_funct3;
  logic [10:0] req_zimm;
  logic [2:0]  req_nf;
  logic        req_mew;
  logic [1:0]  req_mop;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] vec_inst;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [2:0]  fifo_count;

  int n_checks;
  int n_errors;

  // ARITH f6=0 vm=1 vs2=2 vs1=3 f3=000 with vd=1..5
  logic [31:0] fill_w [5] = '{32'h022180D7, 32'h02218157, 32'h022181D7,
                              32'h02218257, 32'h022182D7};

  vec_inst_encoder #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_class  (req_class),
    .req_funct6 (req_funct6),
    .req_vm     (req_vm),
    .req_vd     (req_vd),
    .req_vs1    (req_vs1),
    .req_vs2    (req_vs2),
    .req_funct3 (req_funct3),
    .req_zimm   (req_zimm),
    .req_nf     (req_nf),
    .req_mew    (req_mew),
    .req_mop    (req_mop),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .vec_inst   (vec_inst),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request; fields not used by the class are simply ignored.
  task automatic drive(input int cls, input int f6, input int vm, input int vd, input int vs1,
                       input int vs2, input int f3, input int zimm, input int nf,
                       input int mew, input int mop);
    req_valid  = 1'b1;
    req_class  = 2'(cls);
    req_funct6 = 6'(f6);
    req_vm     = 1'(vm);
    req_vd     = 5'(vd);
    req_vs1    = 5'(vs1);
    req_vs2    = 5'(vs2);
    req_funct3 = 3'(f3);
    req_zimm   = 11'(zimm);
    req_nf     = 3'(nf);
    req_mew    = 1'(mew);
    req_mop    = 2'(mop);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    req_valid  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid  = 1'b0;

    #12;
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_vec_inst",   vec_inst, 0);
    check("rst_err_valid",  32'(err_valid), 0);
    check("rst_err_code",   32'(err_code), 0);
    check("rst_count",      32'(fifo_count), 0);
    reset_n = 1'b1;
    tick();
    check("idle_req_ready", 32'(req_ready), 1);

    // Single ARITH, consumer ready.
    inst_ready = 1'b1;
    drive(0, 0, 1, 1, 3, 2, 0, 0, 0, 0, 0);
    tick();
    req_valid = 1'b0;
    check("arith_valid", 32'(inst_valid), 1);
    check("arith_word",  vec_inst, 32'h022180D7);
    check("arith_count", 32'(fifo_count), 1);
    tick();
    check("arith_drained", 32'(inst_valid), 0);

    // Unit-stride LOAD.
    drive(2, 0, 1, 11, 20, 0, 0, 0, 0, 0, 0);
    tick();
    req_valid = 1'b0;
    check("load_word", vec_inst, 32'h020A0587);
    tick();
    check("load_drained", 32'(fifo_count), 0);

    // Strided STORE nf=1 mop=2 vs2=3 vs1=4 width=101 vs3=6.
    drive(3, 0, 1, 6, 4, 3, 5, 0, 1, 0, 2);
    tick();
    req_valid = 1'b0;
    check("store_word", vec_inst, 32'h2A325327);
    tick();

    // vsetvli serialisation.
    inst_ready = 1'b0;
    drive(1, 0, 0, 10, 15, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 2, 5, 4, 4, 0, 0, 0, 0);
    check("cfg_word",       vec_inst, 32'h0007F557);
    check("cfg_valid",      32'(inst_valid), 1);
    check("cfg_block_rdy",  32'(req_ready), 0);
    tick();
    check("cfg_still_blk",  32'(req_ready), 0);
    check("cfg_count",      32'(fifo_count), 1);
    check("cfg_stable",     vec_inst, 32'h0007F557);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("cfg_popped",     32'(fifo_count), 0);
    check("cfg_rdy_back",   32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    check("post_cfg_count", 32'(fifo_count), 1);
    check("post_cfg_word",  vec_inst, 32'h0442C157);
    inst_ready = 1'b1;
    tick();
    check("post_cfg_drain", 32'(fifo_count), 0);

    // Fill to DEPTH with consumer stalled, then drain in order.
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, i + 1, 3, 2, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 5, 3, 2, 0, 0, 0, 0, 0);
    check("full_count", 32'(fifo_count), 4);
    check("full_ready", 32'(req_ready), 0);
    check("full_head",  vec_inst, fill_w[0]);
    tick();
    check("full_hold_count", 32'(fifo_count), 4);
    check("full_hold_head",  vec_inst, fill_w[0]);
    inst_ready = 1'b1;
    tick();
    check("drain1_count", 32'(fifo_count), 3);
    check("drain1_ready", 32'(req_ready), 1);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain_word%0d", i), vec_inst, fill_w[i]);
      tick();
      req_valid = 1'b0;
    end
    check("drain_empty", 32'(inst_valid), 0);
    check("drain_count", 32'(fifo_count), 0);

    // Illegal requests: nothing pushed, error reported.
    drive(0, 0, 1, 1, 3, 2, 1, 0, 0, 0, 0);
    tick();
    req_valid = 1'b0;
    check("e1_valid", 32'(err_valid), 1);
    check("e1_code",  32'(err_code), 1);
    check("e1_nopush", 32'(fifo_count), 0);
    tick();
    check("e1_pulse", 32'(err_valid), 0);
    check("e1_hold",  32'(err_code), 1);
    drive(2, 0, 1, 1, 1, 0, 3, 0, 0, 0, 0);
    tick();
    req_valid = 1'b0;
    check("e2_code",  32'(err_code), 2);
    check("e2_valid", 32'(err_valid), 1);
    drive(2, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    tick();
    req_valid = 1'b0;
    check("e3_code", 32'(err_code), 3);
    drive(3, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0);
    tick();
    req_valid = 1'b0;
    check("e_prec_code", 32'(err_code), 2);
    check("e_nopush",    32'(inst_valid), 0);
    tick();

    // Asynchronous reset with 3 entries queued.
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, i + 1, 3, 2, 0, 0, 0, 0, 0);
      tick();
    end
    req_valid = 1'b0;
    check("pre_rst_count", 32'(fifo_count), 3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(inst_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    #2 reset_n = 1'b1;
    tick();

    // Flush with 2 queued and a request offered in the same cycle.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, i + 1, 3, 2, 0, 0, 0, 0, 0);
      tick();
    end
    check("pre_flush_count", 32'(fifo_count), 2);
    flush = 1'b1;
    drive(0, 0, 1, 3, 3, 2, 0, 0, 0, 0, 0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_count", 32'(fifo_count), 0);
    check("flush_valid", 32'(inst_valid), 0);
    tick();
    check("flush_no_accept", 32'(fifo_count), 0);

    // Flush releases a pending vsetvli.
    drive(1, 0, 0, 10, 15, 0, 0, 0, 0, 0, 0);
    tick();
    req_valid = 1'b0;
    check("cfg2_block", 32'(req_ready), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cfg2_flush_rdy", 32'(req_ready), 1);
    check("cfg2_flush_cnt", 32'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
